// File: rtl/ysyx_22040127_ifu_if.sv
// ysyx_22040127_ifu_if: instruction-memory and decode handshake bundle of the fetch unit
interface ysyx_22040127_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );
endinterface

// File: rtl/ysyx_22040127_ifu.sv
// ysyx_22040127_ifu: single-outstanding instruction fetch with redirect, stale-response kill and halt
module ysyx_22040127_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22040127_ifu_if.master           bus,
  input  logic                          redirect_valid,
  input  logic [63:0]                   redirect_pc,
  input  logic                          halt,
  output logic [63:0]                   inst_count
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, HALT} state_t;
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d, ipc_q, ipc_d, cnt_q, cnt_d, rpc;
  logic [31:0] inst_q, inst_d;
  logic        kill_q, kill_d, rv_q, iv_q;
  assign rpc = redirect_pc & ~64'd3;
  // Next-state logic: halt beats redirect beats the normal fetch sequence
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    if (halt) state_d = HALT;
    else if (state_q != HALT) begin
      if (redirect_valid) pc_d = rpc;
      case (state_q)
        BOOT: state_d = REQ;
        REQ: if (bus.imem_req_ready) begin
          state_d = WAIT;
          kill_d  = redirect_valid;
        end
        WAIT: if (bus.imem_resp_valid) begin
          state_d = (kill_q || redirect_valid) ? REQ : HOLD;
          kill_d  = 1'b0;
          if (!kill_q && !redirect_valid) begin
            inst_d = bus.imem_resp_data;
            ipc_d  = pc_q;
          end
        end else if (redirect_valid) kill_d = 1'b1;
        HOLD: if (bus.inst_ready) begin
          state_d = REQ;
          cnt_d   = cnt_q + 64'd1;
          pc_d    = redirect_valid ? rpc : pc_q + 64'd4;
        end else if (redirect_valid) state_d = REQ;
        default: state_d = HALT;
      endcase
    end
  end
  // State and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= 32'd0;
      ipc_q   <= 64'd0;
      cnt_q   <= 64'd0;
      rv_q    <= 1'b0;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      rv_q    <= state_d == REQ;
      iv_q    <= state_d == HOLD;
    end
  end
  assign bus.imem_req_valid = rv_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = iv_q;
  assign bus.instruction    = inst_q;
  assign bus.inst_pc        = ipc_q;
  assign inst_count         = cnt_q;
endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// tb_ysyx_22040127_ifu: directed checks of fetch sequencing, stalls, redirects, halt and wrap
module tb_ysyx_22040127_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        halt = 1'b0;
  logic [63:0] inst_count;
  int          checks = 0;
  int          errors = 0;
  ysyx_22040127_ifu_if bus ();
  ysyx_22040127_ifu dut (
    .clk(clk), .rst(rst), .bus(bus.master), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .inst_count(inst_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic outs(input string tag, input logic rv, input logic iv, input logic [63:0] addr);
    chk({tag, " req_valid"}, 64'(bus.imem_req_valid), 64'(rv));
    chk({tag, " inst_valid"}, 64'(bus.inst_valid), 64'(iv));
    chk({tag, " addr"}, bus.imem_req_addr, addr);
  endtask
  task automatic hold(input string tag, input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] cnt);
    outs(tag, 1'b0, 1'b1, pc);
    chk({tag, " instruction"}, 64'(bus.instruction), 64'(ins));
    chk({tag, " inst_pc"}, bus.inst_pc, pc);
    chk({tag, " count"}, inst_count, cnt);
  endtask
  initial begin
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'd0;
    bus.inst_ready      = 1'b0;
    tick();
    outs("reset", 1'b0, 1'b0, 64'h8000_0000);
    chk("reset count", inst_count, 64'd0);
    chk("reset inst_pc", bus.inst_pc, 64'd0);
    rst = 1'b0;
    outs("boot", 1'b0, 1'b0, 64'h8000_0000);
    tick();
    outs("req1", 1'b1, 1'b0, 64'h8000_0000);
    tick();
    outs("wait1", 1'b0, 1'b0, 64'h8000_0000);
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0013;
    tick();
    bus.imem_resp_valid = 1'b0;
    hold("hold1", 32'h0000_0013, 64'h8000_0000, 64'd0);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    outs("req2", 1'b1, 1'b0, 64'h8000_0004);
    chk("req2 count", inst_count, 64'd1);
    tick();
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0010_0093;
    tick();
    bus.imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hold("stall", 32'h0010_0093, 64'h8000_0004, 64'd1);
      tick();
    end
    hold("stall end", 32'h0010_0093, 64'h8000_0004, 64'd1);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    outs("req3", 1'b1, 1'b0, 64'h8000_0008);
    chk("req3 count", inst_count, 64'd2);
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    outs("wait killed", 1'b0, 1'b0, 64'h8000_0100);
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hdead_beef;
    tick();
    bus.imem_resp_valid = 1'b0;
    outs("req after kill", 1'b1, 1'b0, 64'h8000_0100);
    tick();
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0011;
    tick();
    bus.imem_resp_valid = 1'b0;
    hold("hold redirected", 32'h0000_0011, 64'h8000_0100, 64'd2);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    outs("req4", 1'b1, 1'b0, 64'h8000_0104);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    outs("wait old addr", 1'b0, 1'b0, 64'h8000_0400);
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0bad_0bad;
    tick();
    bus.imem_resp_valid = 1'b0;
    outs("req target", 1'b1, 1'b0, 64'h8000_0400);
    tick();
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0022;
    tick();
    bus.imem_resp_valid = 1'b0;
    hold("hold target", 32'h0000_0022, 64'h8000_0400, 64'd3);
    bus.inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0010;
    tick();
    bus.inst_ready = 1'b0; redirect_valid = 1'b0;
    outs("req 10", 1'b1, 1'b0, 64'h8000_0010);
    tick();
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0033;
    tick();
    bus.imem_resp_valid = 1'b0;
    hold("hold 10", 32'h0000_0033, 64'h8000_0010, 64'd4);
    bus.inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    bus.inst_ready = 1'b0; redirect_valid = 1'b0;
    outs("req 200", 1'b1, 1'b0, 64'h8000_0200);
    chk("hold redirect count", inst_count, 64'd5);
    bus.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    outs("req moved", 1'b1, 1'b0, 64'h8000_0300);
    bus.imem_req_ready = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0044;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0800;
    for (int i = 0; i < 4; i++) begin
      outs("halted", 1'b0, 1'b0, 64'h8000_0300);
      tick();
    end
    bus.imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    outs("async reset", 1'b0, 1'b0, 64'h8000_0000);
    chk("async reset count", inst_count, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    outs("resume", 1'b1, 1'b0, 64'h8000_0000);
    bus.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'hffff_ffff_ffff_ffff;
    tick();
    redirect_valid = 1'b0; bus.imem_req_ready = 1'b1;
    outs("top addr", 1'b1, 1'b0, 64'hffff_ffff_ffff_fffc);
    tick();
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0055;
    tick();
    bus.imem_resp_valid = 1'b0;
    hold("hold top", 32'h0000_0055, 64'hffff_ffff_ffff_fffc, 64'd0);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    outs("wrap", 1'b1, 1'b0, 64'd0);
    chk("wrap count", inst_count, 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
